// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES job arbiter: block/key widths, the
// arbiter FSM state encoding and a helper that picks one 128-bit lane
// out of a flattened per-requester bus.
package aes_ctrl_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;

  // Widest flattened bus the lane helper accepts; callers zero-extend to this.
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  function automatic logic [AES_BLK_W-1:0] get_lane(
    input logic [MAX_REQ*AES_BLK_W-1:0] i_bus,
    input int unsigned                  i_idx
  );
    return i_bus[i_idx*AES_BLK_W +: AES_BLK_W];
  endfunction

endpackage

// File: rtl/aes_job_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after
// last_grant+1 (wrapping modulo NUM_REQ) wins. The pointer itself is kept
// by the caller so this block holds no state.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id
);

  logic w_found;

  // Walk the requesters in priority order starting just after the last winner.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && i_req[j] && (j == ((int'(i_last_grant) + off) % NUM_REQ))) begin
          o_grant[j] = 1'b1;
          o_grant_id = ID_W'(j);
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Round-robin job scheduler sharing one AES-128 core among NUM_REQ
// requesters. One job is in flight at a time: accept in IDLE, pulse
// core_start in ISSUE, wait for core_done in BUSY, hand back the tagged
// ciphertext in RESP.
// Optional build macro AES_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts
// a job after TIMEOUT_CYCLES cycles with rsp_err=1 and rsp_data=0.
module aes_job_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_plaintext,
  input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key,
  output logic                           core_start,
  output logic [AES_BLK_W-1:0]           core_plaintext,
  output logic [AES_KEY_W-1:0]           core_key,
  input  logic                           core_done,
  input  logic [AES_BLK_W-1:0]           core_ciphertext,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [AES_BLK_W-1:0]           rsp_data,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [15:0]                    jobs_done
);

  arb_state_e                   r_state;
  arb_state_e                   w_state_next;
  logic [ID_W-1:0]              r_last_grant;
  logic [AES_BLK_W-1:0]         r_pt;
  logic [AES_KEY_W-1:0]         r_key;
  logic [ID_W-1:0]              r_rsp_id;
  logic [AES_BLK_W-1:0]         r_rsp_data;
  logic [15:0]                  r_jobs_done;
  logic [NUM_REQ-1:0]           w_grant;
  logic [ID_W-1:0]              w_grant_id;
  logic                         w_accept;
  logic                         w_rsp_hs;
  logic                         w_timeout;
  logic [MAX_REQ*AES_BLK_W-1:0] w_pt_ext;
  logic [MAX_REQ*AES_KEY_W-1:0] w_key_ext;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_id   (w_grant_id)
  );

  assign w_pt_ext  = (MAX_REQ*AES_BLK_W)'(req_plaintext);
  assign w_key_ext = (MAX_REQ*AES_KEY_W)'(req_key);

  assign w_accept = (r_state == IDLE) && (|req_valid);
  assign w_rsp_hs = (r_state == RESP) && rsp_ready;

  // The grant is combinational, so it is also forced low while reset is held.
  assign req_ready      = (rst_n && (r_state == IDLE)) ? w_grant : '0;
  assign core_start     = (r_state == ISSUE);
  assign core_plaintext = r_pt;
  assign core_key       = r_key;
  assign rsp_valid      = (r_state == RESP);
  assign rsp_id         = r_rsp_id;
  assign rsp_data       = r_rsp_data;
  assign busy           = (r_state != IDLE);
  assign jobs_done      = r_jobs_done;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WDOG_W-1:0] r_wdog;
  logic              r_rsp_err;

  // A late core_done still wins over the watchdog in the same cycle.
  assign w_timeout = (r_state == BUSY) && !core_done &&
                     (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = r_rsp_err;

  // Watchdog restarts with each core_start and counts cycles spent in BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state == ISSUE) begin
      r_wdog <= '0;
    end else if (r_state == BUSY) begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  // Error flag is raised by an abort and dropped when the response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err <= 1'b0;
    end else if ((r_state == BUSY) && core_done) begin
      r_rsp_err <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_err <= 1'b1;
    end else if (w_rsp_hs) begin
      r_rsp_err <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; RESP always returns to IDLE so a grant never shares the handshake cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (|req_valid) w_state_next = ISSUE;
      ISSUE:   w_state_next = BUSY;
      BUSY:    if (core_done || w_timeout) w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Capture the winning job into the holding registers that feed the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pt     <= '0;
      r_key    <= '0;
      r_rsp_id <= '0;
    end else if (w_accept) begin
      r_pt     <= get_lane(w_pt_ext, 32'(w_grant_id));
      r_key    <= get_lane(w_key_ext, 32'(w_grant_id));
      r_rsp_id <= w_grant_id;
    end
  end

  // Latch the ciphertext on completion, or zero it on a watchdog abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
    end else if ((r_state == BUSY) && core_done) begin
      r_rsp_data <= core_ciphertext;
    end else if (w_timeout) begin
      r_rsp_data <= '0;
    end
  end

  // Advance the round-robin pointer and job counter only when a response is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_jobs_done  <= '0;
    end else if (w_rsp_hs) begin
      r_last_grant <= r_rsp_id;
      r_jobs_done  <= r_jobs_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Scoreboard bench for aes_job_arbiter: stimulus pushes expected grants and
// responses into queues, a negedge monitor pops and compares them. A small
// core model returns the FIPS-197 ciphertext for the reference vector and a
// simple mix of plaintext/key otherwise, after a fixed latency.
module tb_aes_job_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int CORE_LAT = 10;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_plaintext;
  logic [NUM_REQ*128-1:0] req_key;
  logic                   core_start;
  logic [127:0]           core_plaintext;
  logic [127:0]           core_key;
  logic                   core_done;
  logic [127:0]           core_ciphertext;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [127:0]           rsp_data;
  logic                   rsp_err;
  logic                   busy;
  logic [15:0]            jobs_done;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [127:0]    data;
    logic            err;
  } rsp_t;

  rsp_t rspQ[$];
  int   grantQ[$];
  int   vectorCount = 0;
  int   failCount   = 0;
  int   grantCount  = 0;

  aes_job_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ID_W           (ID_W),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_plaintext   (req_plaintext),
    .req_key         (req_key),
    .core_start      (core_start),
    .core_plaintext  (core_plaintext),
    .core_key        (core_key),
    .core_done       (core_done),
    .core_ciphertext (core_ciphertext),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .busy            (busy),
    .jobs_done       (jobs_done)
  );

  always #5 clk = ~clk;

  // Reference behaviour of the AES core used by both the core model and the expectations.
  function automatic logic [127:0] coreModel(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    vectorCount++;
    failCount++;
    $display("[TB] FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  // Core model: fixed latency after core_start, optional hang, optional spurious pulse.
  logic [127:0] coreCt;
  int           coreCnt;
  int           spurReq  = 0;
  int           spurSeen = 0;
  logic         coreHang = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_done       <= 1'b0;
      core_ciphertext <= '0;
      coreCnt         <= 0;
      coreCt          <= '0;
    end else begin
      core_done <= 1'b0;
      if (spurReq != spurSeen) begin
        spurSeen        <= spurSeen + 1;
        core_done       <= 1'b1;
        core_ciphertext <= 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
      end
      if (core_start) begin
        coreCnt <= CORE_LAT;
        coreCt  <= coreModel(core_plaintext, core_key);
      end else if (coreCnt != 0) begin
        coreCnt <= coreCnt - 1;
        if (coreCnt == 1 && !coreHang) begin
          core_done       <= 1'b1;
          core_ciphertext <= coreCt;
        end
      end
    end
  end

  // Monitor: checks grants, the start pulse that follows, and every response handshake.
  logic startPending = 1'b0;
  logic pulseCheck   = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pulseCheck) begin
        checkOutput("startPulseWidth", 128'(core_start), 128'd0);
        pulseCheck = 1'b0;
      end
      if (startPending) begin
        checkOutput("startLatency", 128'(core_start), 128'd1);
        startPending = 1'b0;
        pulseCheck   = 1'b1;
      end
      if (req_ready != '0) begin
        int g;
        grantCount++;
        startPending = 1'b1;
        checkOutput("grantOneHot", 128'($onehot(req_ready)), 128'd1);
        if (grantQ.size() == 0) begin
          vectorCount++;
          failCount++;
          $display("[TB] FAIL unexpectedGrant: got req_ready %b, expected none", req_ready);
        end else begin
          g = grantQ.pop_front();
          checkOutput("grantId", 128'(req_ready), 128'(1) << g);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_t e;
        if (rspQ.size() == 0) begin
          vectorCount++;
          failCount++;
          $display("[TB] FAIL unexpectedRsp: got id %0d data %h, expected none", rsp_id, rsp_data);
        end else begin
          e = rspQ.pop_front();
          checkOutput("rspId", 128'(rsp_id), 128'(e.id));
          checkOutput("rspData", rsp_data, e.data);
          checkOutput("rspErr", 128'(rsp_err), 128'(e.err));
        end
      end
    end else begin
      startPending = 1'b0;
      pulseCheck   = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid);
    @(posedge clk);
    #1;
    req_valid = valid;
  endtask

  task automatic pushJob(input int id);
    grantQ.push_back(id);
    rspQ.push_back('{ID_W'(id), coreModel(req_plaintext[id*128 +: 128], req_key[id*128 +: 128]), 1'b0});
  endtask

  task automatic waitGrants(input int target, input string name);
    int n = 0;
    while (grantCount < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (grantCount < target) reportTimeout(name);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((rspQ.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (rspQ.size() != 0 || busy) reportTimeout(name);
  endtask

  task automatic checkAllZero(input string prefix);
    checkOutput({prefix, "Ctl"}, 128'({req_ready, core_start, rsp_valid, rsp_err, busy, rsp_id, jobs_done}), 128'd0);
    checkOutput({prefix, "CorePt"}, core_plaintext, 128'd0);
    checkOutput({prefix, "CoreKey"}, core_key, 128'd0);
    checkOutput({prefix, "RspData"}, rsp_data, 128'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout: simulation still running, expected completion");
    $fatal(1, "[TB] global time limit reached");
  end

  initial begin
    int target;
    int n;

    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_plaintext[i*128 +: 128] = {4{32'ha0000000 + 32'(i)}};
      req_key[i*128 +: 128]       = {4{32'h0b000000 + 32'(i * 32'h111)}};
    end
    req_plaintext[2*128 +: 128] = FIPS_PT;
    req_key[2*128 +: 128]       = FIPS_KEY;

    // Reset values.
    @(posedge clk);
    @(posedge clk);
    #1;
    checkAllZero("reset");

    // Single FIPS-197 job from requester 2.
    $display("[TB] single FIPS-197 job");
    rst_n = 1'b1;
    grantQ.push_back(2);
    rspQ.push_back('{2'd2, FIPS_CT, 1'b0});
    target = grantCount + 1;
    applyStimulus(4'b0100);
    waitGrants(target, "waitFipsGrant");
    req_valid = '0;
    waitDrain("drainFips");
    checkOutput("jobsDoneFips", 128'(jobs_done), 128'd1);

    // All requesters valid from reset: order 0,1,2,3,0.
    $display("[TB] round-robin with all requesters valid");
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    checkAllZero("rstAllValid");
    pushJob(0);
    pushJob(1);
    pushJob(2);
    pushJob(3);
    pushJob(0);
    target = grantCount + 5;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitGrants(target, "waitRrGrants");
    req_valid = '0;
    waitDrain("drainRr");
    checkOutput("jobsDoneRr", 128'(jobs_done), 128'd5);

    // Response held off for 5 cycles; requester 3 waits behind it.
    $display("[TB] response back-pressure");
    rsp_ready = 1'b0;
    pushJob(1);
    pushJob(3);
    target = grantCount + 1;
    applyStimulus(4'b1010);
    waitGrants(target, "waitHoldGrant");
    req_valid = 4'b1000;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rsp_valid) reportTimeout("waitHoldRsp");
    for (int c = 0; c < 5; c++) begin
      checkOutput("holdCtl", 128'({rsp_valid, rsp_id, req_ready}), 128'({1'b1, 2'd1, 4'b0000}));
      checkOutput("holdData", rsp_data, coreModel(req_plaintext[1*128 +: 128], req_key[1*128 +: 128]));
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    waitGrants(target + 1, "waitGrantAfterHold");
    req_valid = '0;
    waitDrain("drainHold");
    checkOutput("jobsDoneHold", 128'(jobs_done), 128'd7);

    // Spurious core_done while idle, then a normal job.
    $display("[TB] spurious core_done in IDLE");
    spurReq = spurReq + 1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      checkOutput("spuriousIdle", 128'({rsp_valid, busy}), 128'd0);
    end
    pushJob(0);
    target = grantCount + 1;
    applyStimulus(4'b0001);
    waitGrants(target, "waitPostSpurGrant");
    req_valid = '0;
    waitDrain("drainPostSpur");
    checkOutput("jobsDoneSpur", 128'(jobs_done), 128'd8);

    // Reset while the core is busy: job dropped, requester 0 first afterwards.
    $display("[TB] reset during BUSY");
    grantQ.push_back(2);
    target = grantCount + 1;
    applyStimulus(4'b0100);
    waitGrants(target, "waitBusyGrant");
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busyBeforeReset", 128'({busy, rsp_valid}), 128'({1'b1, 1'b0}));
    rst_n     = 1'b0;
    req_valid = 4'b1001;
    #1;
    checkAllZero("rstBusy");
    pushJob(0);
    target = grantCount + 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitGrants(target, "waitGrantAfterReset");
    req_valid = '0;
    waitDrain("drainAfterReset");
    checkOutput("jobsDoneAfterReset", 128'(jobs_done), 128'd1);

`ifdef AES_ARB_TIMEOUT_EN
    // Core never finishes: watchdog aborts after 64 BUSY cycles.
    $display("[TB] watchdog abort");
    coreHang = 1'b1;
    grantQ.push_back(1);
    rspQ.push_back('{2'd1, 128'd0, 1'b1});
    target = grantCount + 1;
    applyStimulus(4'b0010);
    waitGrants(target, "waitTimeoutGrant");
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("timeoutCycles", 128'(n), 128'd65);
    waitDrain("drainTimeout");
    coreHang = 1'b0;
    checkOutput("jobsDoneTimeout", 128'(jobs_done), 128'd2);
`endif

    repeat (2) @(posedge clk);
    if (grantQ.size() != 0 || rspQ.size() != 0) begin
      vectorCount++;
      failCount++;
      $display("[TB] FAIL leftoverExpect: got %0d grants %0d rsps pending, expected 0", grantQ.size(), rspQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule

// File: doc/aes_job_arbiter.md
Name: aes_job_arbiter

Overview:
- Round-robin scheduler that shares a single AES-128 encryption core between NUM_REQ independent requesters.
- Accepts one plaintext/key job at a time over a valid/ready handshake, then issues it to the core with a one-cycle start pulse.
- Waits for the core's done strobe and returns the ciphertext tagged with the requester ID.
- Sits between the host-side job queues and the AES core; it is the only block that drives the core's start, plaintext and key inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ).
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester job valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_plaintext  in  NUM_REQ*128  flattened plaintexts; requester i occupies [i*128 +: 128].
- req_key  in  NUM_REQ*128  flattened keys; same packing as req_plaintext.
- core_start  out  1  one-cycle start pulse to the AES core.
- core_plaintext  out  128  plaintext held stable to the core.
- core_key  out  128  key held stable to the core.
- core_done  in  1  core completion strobe.
- core_ciphertext  in  128  core result, valid while core_done is high.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  ID of the requester that owns the response.
- rsp_data  out  128  ciphertext.
- rsp_err  out  1  watchdog abort flag; constant 0 without the optional feature.
- busy  out  1  high whenever the FSM is not in IDLE.
- jobs_done  out  16  count of completed responses; wraps at 0xFFFF.

Behaviour:
- Reset values: all outputs 0. Round-robin pointer last_grant = NUM_REQ-1, so requester 0 wins first. FSM in IDLE.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - If any req_valid is high, grant g is the first set bit searching upward from last_grant+1, modulo NUM_REQ.
  - In the same cycle: req_ready[g]=1 (combinational), plaintext[g] and key[g] captured into holding registers, rsp_id <= g. Next state ISSUE.
  - If no req_valid is high, remain in IDLE.
- ISSUE:
  - core_start=1 for exactly this cycle. Next state BUSY.
  - core_done is ignored in ISSUE.
- BUSY:
  - On core_done=1: rsp_data <= core_ciphertext. Next state RESP.
  - Otherwise remain in BUSY.
- RESP:
  - rsp_valid=1. rsp_id and rsp_data are held stable.
  - On rsp_ready=1: last_grant <= rsp_id, jobs_done increments, next state IDLE.
  - A new grant cannot occur in the same cycle as the response handshake.
- core_plaintext and core_key are driven from the holding registers and change only at capture in IDLE.
- Minimum latency: accept to core_start 1 cycle; core_done to rsp_valid 1 cycle; back-to-back job spacing = core latency + 3 cycles.
- Fairness: a requester that keeps req_valid high is served within NUM_REQ jobs.
- A requester that deasserts req_valid before being granted is skipped; no error.
- A core_done while in IDLE or RESP is ignored.
- Reset mid-operation: FSM returns to IDLE and the in-flight job is dropped without a response. The core shares rst_n.
- jobs_done wraps from 0xFFFF to 0 with no flag.

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter clears on core_start and increments each cycle in BUSY.
  - When it reaches TIMEOUT_CYCLES-1 without core_done, the FSM goes to RESP with rsp_err=1 and rsp_data=0.
  - rsp_err clears on the response handshake.
  - If core_done arrives in the same cycle as the timeout, core_done wins and rsp_err=0.
- Without the macro: no counter is built, rsp_err is tied to 0, and BUSY waits indefinitely.

Decomposition:
- Package aes_ctrl_pkg holds:
  - AES_BLK_W=128 and AES_KEY_W=128;
  - the FSM state enum (IDLE, ISSUE, BUSY, RESP) with 2-bit encoding;
  - a function extracting lane i from a flattened NUM_REQ*128 bus.
- One sub-module, rr_arbiter:
  - Pure combinational round-robin pick over req_valid, parameterised by NUM_REQ.
  - Inputs: req vector and last_grant. Outputs: one-hot grant and encoded ID.
  - Pointer storage stays in aes_job_arbiter.

Test Plan:
- Single job, FIPS-197 vector: requester 2 sends key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, with a core model of 10-cycle latency. Required: core_start exactly 1 cycle after acceptance; rsp_id=2; rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a; jobs_done=1.
- All four requesters hold req_valid high from reset. Required: grant order 0,1,2,3,0; exactly one req_ready bit high per grant.
- rsp_ready held low for 5 cycles in RESP. Required: rsp_valid, rsp_id and rsp_data stable throughout; no new req_ready until after the handshake.
- Spurious core_done pulse while in IDLE, then a normal job. Required: no response from the spurious pulse; the normal job completes correctly.
- rst_n asserted in BUSY. Required: all outputs 0 immediately; after release, requester 0 is granted first.
- With AES_ARB_TIMEOUT_EN, core never asserts done. Required: rsp_valid=1, rsp_err=1, rsp_data=0 after 64 BUSY cycles.
